sseg_refresh_ctrl: RTL
======================

Name: sseg_refresh_ctrl

Overview:
Upstream frame controller for the serial 7-segment display path. It holds shadow copies of the display value, digit-enable (LES) and decimal-point masks written by the CPU/bus side. It generates the flash square wave. It issues one-cycle Start pulses that launch a 64-bit serial shift, and holds the presented Hexs/LES/point stable for the whole shift window. Start is issued on content change, flash toggle or periodic refresh.

Parameters:
SHIFT_CYCLES, 160, cycles after a Start during which outputs stay frozen and no new Start is issued (must cover the full serial shift); minimum 1
FLASH_DIV, 25000000, flash half-period in clk cycles; minimum 2
REFRESH_DIV, 1000000, period in clk cycles of the unconditional refresh tick; minimum 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe, sampled on rising clk
wr_sel  in  2  0=Hexs, 1=LES (wr_data[7:0]), 2=point (wr_data[7:0]), 3=force refresh (no data change)
wr_data  in  32  write data
Hexs  out  32  frozen display value for the current frame
LES  out  8  frozen digit-enable mask
point  out  8  frozen decimal-point mask
flash  out  1  blink square wave
Start  out  1  one-cycle frame launch pulse
busy  out  1  high while a frame is in flight

Behaviour:
- Reset (async, rst_n=0): Hexs, LES, point, shadows = 0; Start=0; busy=0; flash=0; flash/refresh/hold counters = 0; state=IDLE; dirty=1, so the first frame launches right after reset release.
- Shadow write: wr_en=1 at an edge updates the selected shadow register and sets dirty. Writes are accepted in every state, and no write is ever dropped. wr_sel=3 sets dirty only.
- Flash counter: counts 0..FLASH_DIV-1. On wrap it toggles flash and sets dirty.
- Refresh counter: counts 0..REFRESH_DIV-1. On wrap it sets dirty.
- FSM states:
  - IDLE, busy=0. At an edge with dirty=1, go to SEND. At that same edge, copy the shadows into Hexs/LES/point, assert Start and busy, and clear dirty.
  - SEND, Start=1 for exactly one cycle. Next edge: Start=0, load hold counter with SHIFT_CYCLES-1, go to HOLD.
  - HOLD, busy=1, outputs frozen. Decrement each edge. At count 0, go to IDLE and drop busy.
- Latency: a write sampled at edge k while IDLE gives Start=1 and the new Hexs visible from edge k+1 to k+2.
- Frame spacing: minimum Start-to-Start spacing is SHIFT_CYCLES+2 edges.
- Simultaneous events:
  - A write at the same edge as the IDLE->SEND snapshot goes to the shadow only. The snapshot takes the pre-write shadow, and dirty is set again (set wins over clear), so a second frame follows.
  - Any number of dirty sources during SEND/HOLD merge into a single pending frame.
- Outputs Hexs/LES/point change only at the IDLE->SEND edge or at reset.
- flash is the only output that may change during HOLD.
- Reset asserted mid-frame immediately returns all outputs to their reset values. After release, a fresh frame launches from the shadows, which are now 0.

Test Plan:
- Reset release with no writes -> Start pulses 1 cycle after the first edge; Hexs=0, LES=0, point=0; busy high for SHIFT_CYCLES+1 cycles.
- After idle, write sel0 data 32'h1234ABCD at edge k -> Start=1 and Hexs=32'h1234ABCD during cycle k+1..k+2; LES/point unchanged.
- Write sel0 32'hFFFF0000 during HOLD -> Hexs holds its old value until HOLD ends; exactly one new Start follows at IDLE.
- Writes of sel1=8'h0F and sel2=8'hA0 in consecutive HOLD cycles -> a single subsequent frame carries LES=8'h0F and point=8'hA0.
- Write landing on the snapshot edge -> the first frame has the old value, and a second Start SHIFT_CYCLES+2 edges later has the new value.
- FLASH_DIV=8, REFRESH_DIV=1000 with no writes -> flash toggles every 8 cycles, each toggle triggers a frame (or a merged one if busy); assert rst_n=0 mid-HOLD -> Start/busy/outputs become 0 that cycle.

Source files
------------

// File: rtl/sseg_refresh_if.sv
// Bus bundle between the CPU-side writer and the 7-segment frame controller.
interface sseg_refresh_if;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;
  logic [31:0] Hexs;
  logic [7:0]  LES;
  logic [7:0]  point;
  logic        flash;
  logic        Start;
  logic        busy;

  modport master (
    output wr_en, wr_sel, wr_data,
    input  Hexs, LES, point, flash, Start, busy
  );

  modport slave (
    input  wr_en, wr_sel, wr_data,
    output Hexs, LES, point, flash, Start, busy
  );
endinterface

// File: rtl/sseg_refresh_ctrl.sv
// Frame controller for the serial 7-segment path: shadows bus writes,
// generates the flash square wave, and launches one frozen frame per
// Start pulse whenever content changes, flash toggles or refresh ticks.
module sseg_refresh_ctrl #(
  parameter int SHIFT_CYCLES = 160,
  parameter int FLASH_DIV    = 25000000,
  parameter int REFRESH_DIV  = 1000000
) (
  input  logic      clk,
  input  logic      rst_n,
  sseg_refresh_if.slave bus
);

  localparam int HOLD_W  = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;
  localparam int FLASH_W = $clog2(FLASH_DIV);
  localparam int REFR_W  = $clog2(REFRESH_DIV);

  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(SHIFT_CYCLES - 1);
  localparam logic [FLASH_W-1:0] FLASH_TOP = FLASH_W'(FLASH_DIV - 1);
  localparam logic [REFR_W-1:0]  REFR_TOP  = REFR_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t r_state;
  state_t w_state_n;

  logic [31:0]        r_sh_hexs;
  logic [7:0]         r_sh_les;
  logic [7:0]         r_sh_point;
  logic [31:0]        r_hexs;
  logic [7:0]         r_les;
  logic [7:0]         r_point;
  logic               r_flash;
  logic               r_start;
  logic               r_busy;
  logic               r_dirty;
  logic [FLASH_W-1:0] r_flash_cnt;
  logic [REFR_W-1:0]  r_refr_cnt;
  logic [HOLD_W-1:0]  r_hold_cnt;

  logic w_flash_wrap;
  logic w_refr_wrap;
  logic w_dirty_set;
  logic w_snapshot;
  logic w_hold_load;
  logic w_hold_dec;
  logic w_frame_done;

  assign w_flash_wrap = (r_flash_cnt == FLASH_TOP);
  assign w_refr_wrap  = (r_refr_cnt == REFR_TOP);
  assign w_dirty_set  = bus.wr_en | w_flash_wrap | w_refr_wrap;

  // Shadow registers: every write lands here regardless of FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_hexs  <= '0;
      r_sh_les   <= '0;
      r_sh_point <= '0;
    end else if (bus.wr_en) begin
      case (bus.wr_sel)
        2'd0:    r_sh_hexs  <= bus.wr_data;
        2'd1:    r_sh_les   <= bus.wr_data[7:0];
        2'd2:    r_sh_point <= bus.wr_data[7:0];
        default: ;
      endcase
    end
  end

  // Flash half-period divider and square wave
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flash_cnt <= '0;
      r_flash     <= 1'b0;
    end else if (w_flash_wrap) begin
      r_flash_cnt <= '0;
      r_flash     <= ~r_flash;
    end else begin
      r_flash_cnt <= r_flash_cnt + 1'b1;
    end
  end

  // Unconditional refresh tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refr_cnt <= '0;
    end else if (w_refr_wrap) begin
      r_refr_cnt <= '0;
    end else begin
      r_refr_cnt <= r_refr_cnt + 1'b1;
    end
  end

  // Pending-frame flag; a new dirty source beats the snapshot clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dirty <= 1'b1;
    end else if (w_dirty_set) begin
      r_dirty <= 1'b1;
    end else if (w_snapshot) begin
      r_dirty <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // FSM next-state and per-edge control strobes
  always_comb begin
    w_state_n    = r_state;
    w_snapshot   = 1'b0;
    w_hold_load  = 1'b0;
    w_hold_dec   = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_dirty) begin
          w_state_n  = SEND;
          w_snapshot = 1'b1;
        end
      end
      SEND: begin
        w_state_n   = HOLD;
        w_hold_load = 1'b1;
      end
      HOLD: begin
        if (r_hold_cnt == '0) begin
          w_state_n    = IDLE;
          w_frame_done = 1'b1;
        end else begin
          w_hold_dec = 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Hold window counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (w_hold_load) begin
      r_hold_cnt <= HOLD_LOAD;
    end else if (w_hold_dec) begin
      r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end

  // Frame outputs: snapshot shadows, pulse Start, track busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hexs  <= '0;
      r_les   <= '0;
      r_point <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_start <= w_snapshot;
      if (w_snapshot) begin
        r_hexs  <= r_sh_hexs;
        r_les   <= r_sh_les;
        r_point <= r_sh_point;
        r_busy  <= 1'b1;
      end else if (w_frame_done) begin
        r_busy  <= 1'b0;
      end
    end
  end

  assign bus.Hexs  = r_hexs;
  assign bus.LES   = r_les;
  assign bus.point = r_point;
  assign bus.flash = r_flash;
  assign bus.Start = r_start;
  assign bus.busy  = r_busy;

endmodule
